// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with threshold flags, sticky
//            overflow/underflow flags and synchronous flush.
//            Define SYNC_FIFO_SVA_EN to compile in full/empty/count checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_valid,
  output logic                     full_flag,
  output logic                     empty_flag,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     overflow_flag,
  output logic                     underflow_flag
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_read_data;
  logic               r_read_valid;
  logic               r_overflow;
  logic               r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Status is decoded only from the registered count, so it cannot glitch on
  // request inputs.
  assign w_full  = (r_count == C_DEPTH_CNT);
  assign w_empty = (r_count == '0);

  assign w_wr_acc = write_enable && !w_full && !flush;
  assign w_rd_acc = read_enable && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (flush) begin
      // read_data and the array are intentionally left untouched.
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_read_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr    <= r_rd_ptr + C_PTR_W'(1);
        r_read_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (write_enable && w_full) begin
        r_overflow <= 1'b1;
      end
      if (read_enable && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign read_data      = r_read_data;
  assign read_valid     = r_read_valid;
  assign full_flag      = w_full;
  assign empty_flag     = w_empty;
  assign almost_full    = (32'(r_count) >= AF_LEVEL);
  assign almost_empty   = (32'(r_count) <= AE_LEVEL);
  assign word_count     = r_count;
  assign overflow_flag  = r_overflow;
  assign underflow_flag = r_underflow;

`ifdef SYNC_FIFO_SVA_EN
  a_full_decode : assert property (@(posedge clk) disable iff (!rst_n)
    full_flag == (word_count == C_DEPTH_CNT))
    else $error("sync_fifo_param: full_flag does not match word_count");

  a_empty_decode : assert property (@(posedge clk) disable iff (!rst_n)
    empty_flag == (word_count == '0))
    else $error("sync_fifo_param: empty_flag does not match word_count");

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    word_count <= C_DEPTH_CNT)
    else $error("sync_fifo_param: word_count exceeds DEPTH");

  a_no_inc_full : assert property (@(posedge clk) disable iff (!rst_n)
    full_flag |=> word_count <= $past(word_count))
    else $error("sync_fifo_param: count incremented while full");

  a_no_dec_empty : assert property (@(posedge clk) disable iff (!rst_n)
    empty_flag |=> word_count >= $past(word_count))
    else $error("sync_fifo_param: count decremented while empty");

  a_not_full_and_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(full_flag && empty_flag))
    else $error("sync_fifo_param: full_flag and empty_flag both high");
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       write_enable;
  logic [7:0] write_data;
  logic       read_enable;
  logic [7:0] read_data;
  logic       read_valid;
  logic       full_flag;
  logic       empty_flag;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] word_count;
  logic       overflow_flag;
  logic       underflow_flag;

  int checks;
  int failures;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .read_enable    (read_enable),
    .read_data      (read_data),
    .read_valid     (read_valid),
    .full_flag      (full_flag),
    .empty_flag     (empty_flag),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .word_count     (word_count),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given requests; returns 1 time unit after the edge.
  task automatic cycle(input logic fl, input logic we, input logic [7:0] wd, input logic re);
    flush        = fl;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(word_count), 32'd0);
    check({tag, "_empty"}, 32'(empty_flag), 32'd1);
    check({tag, "_full"}, 32'(full_flag), 32'd0);
    check({tag, "_ae"}, 32'(almost_empty), 32'd1);
    check({tag, "_af"}, 32'(almost_full), 32'd0);
    check({tag, "_rdata"}, 32'(read_data), 32'd0);
    check({tag, "_rvalid"}, 32'(read_valid), 32'd0);
    check({tag, "_ovf"}, 32'(overflow_flag), 32'd0);
    check({tag, "_unf"}, 32'(underflow_flag), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    write_enable = 1'b0;
    write_data = 8'h00;
    read_enable = 1'b0;

    #1;
    check_reset_values("reset");
    #11;
    rst_n = 1'b1;

    // Fill with 0x00..0x0F, checking threshold boundaries along the way.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0);
      check("fill_count", 32'(word_count), 32'(i + 1));
      if (i == 1)  check("ae_at_2", 32'(almost_empty), 32'd1);
      if (i == 2)  check("ae_at_3", 32'(almost_empty), 32'd0);
      if (i == 12) check("af_at_13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_at_14", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(full_flag), 32'd1);
    check("fill_af", 32'(almost_full), 32'd1);
    check("fill_ovf", 32'(overflow_flag), 32'd0);
    check("fill_rvalid", 32'(read_valid), 32'd0);

    // Write while full is dropped and flagged.
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    check("ovf_count", 32'(word_count), 32'd16);
    check("ovf_flag", 32'(overflow_flag), 32'd1);
    check("ovf_full", 32'(full_flag), 32'd1);

    // Drain in order; 0xAA must not appear.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check("drain_data", 32'(read_data), 32'(i));
      check("drain_valid", 32'(read_valid), 32'd1);
      check("drain_count", 32'(word_count), 32'(15 - i));
    end
    check("drain_empty", 32'(empty_flag), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_valid", 32'(read_valid), 32'd0);

    // Read while empty.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("unf_flag", 32'(underflow_flag), 32'd1);
    check("unf_valid", 32'(read_valid), 32'd0);
    check("unf_data_held", 32'(read_data), 32'h0F);
    check("unf_empty", 32'(empty_flag), 32'd1);
    check("unf_ovf_sticky", 32'(overflow_flag), 32'd1);

    // Five entries with both error flags set, then flush together with a write.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    check("pre_flush_count", 32'(word_count), 32'd5);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    check("flush_count", 32'(word_count), 32'd0);
    check("flush_empty", 32'(empty_flag), 32'd1);
    check("flush_ovf", 32'(overflow_flag), 32'd0);
    check("flush_unf", 32'(underflow_flag), 32'd0);
    check("flush_rvalid", 32'(read_valid), 32'd0);
    check("flush_rdata_kept", 32'(read_data), 32'h0F);

    // Hold at 8 and stream 20 simultaneous read/write cycles across the wrap.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    check("stream_pre_count", 32'(word_count), 32'd8);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, 8'(8'h38 + k), 1'b1);
      check("stream_data", 32'(read_data), 32'(8'h30 + k));
      check("stream_valid", 32'(read_valid), 32'd1);
      check("stream_count", 32'(word_count), 32'd8);
    end

    // Fill to full, then simultaneous read and write: only the read is taken.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    check("full2_full", 32'(full_flag), 32'd1);
    cycle(1'b0, 1'b1, 8'hBB, 1'b1);
    check("rw_full_count", 32'(word_count), 32'd15);
    check("rw_full_ovf", 32'(overflow_flag), 32'd1);
    check("rw_full_data", 32'(read_data), 32'h44);
    check("rw_full_valid", 32'(read_valid), 32'd1);

    // Flush, then simultaneous read and write on empty: only the write is taken.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("flush2_count", 32'(word_count), 32'd0);
    cycle(1'b0, 1'b1, 8'h61, 1'b1);
    check("rw_empty_count", 32'(word_count), 32'd1);
    check("rw_empty_unf", 32'(underflow_flag), 32'd1);
    check("rw_empty_valid", 32'(read_valid), 32'd0);
    check("rw_empty_data_held", 32'(read_data), 32'h44);
    cycle(1'b0, 1'b1, 8'h62, 1'b1);
    check("nofall_data", 32'(read_data), 32'h61);
    check("nofall_valid", 32'(read_valid), 32'd1);
    check("nofall_count", 32'(word_count), 32'd1);

    // Asynchronous reset between edges mid-burst.
    write_enable = 1'b1;
    write_data   = 8'h70;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    write_enable = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the next generation of the fixed depth-16 FIFO. It generalises data width, depth and almost-full/almost-empty thresholds. It adds sticky overflow/underflow error flags, a synchronous flush, and an optional compiled-in set of full/empty assertions. It sits between a single-clock producer and consumer as the team's standard buffering element.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AF_LEVEL`, 14, `almost_full` asserts when `word_count` ≥ `AF_LEVEL`
- `AE_LEVEL`, 2, `almost_empty` asserts when `word_count` ≤ `AE_LEVEL`
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of contents and error flags
- `write_enable`  in  1  write request
- `write_data`  in  `WIDTH`  data to write
- `read_enable`  in  1  read request
- `read_data`  out  `WIDTH`  registered read data
- `read_valid`  out  1  `read_data` holds a newly popped word this cycle
- `full_flag`  out  1  `word_count` == `DEPTH`
- `empty_flag`  out  1  `word_count` == 0
- `almost_full`  out  1  threshold flag, see above
- `almost_empty`  out  1  threshold flag, see above
- `word_count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH` inclusive
- `overflow_flag`  out  1  sticky: a write was attempted while full
- `underflow_flag`  out  1  sticky: a read was attempted while empty

## Operation
- Storage: `DEPTH`×`WIDTH` register array. Write and read pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- Write accepted iff `write_enable` && !`full_flag`: store `write_data` at the write pointer, then increment it.
- Read accepted iff `read_enable` && !`empty_flag`: load the word at the read pointer into `read_data`, increment the read pointer, and pulse `read_valid` for one cycle.
- Count update:
  - write accepted, no read: +1
  - read accepted, no write: −1
  - both accepted: unchanged
  - neither: unchanged
- Write while full: the data is dropped, the write pointer and count are unchanged, and `overflow_flag` is set.
- Read while empty: nothing is popped, `read_data` holds its value, `read_valid` = 0, and `underflow_flag` is set.
- Simultaneous read and write when full: only the read is accepted. Count becomes `DEPTH-1` and `overflow_flag` is set.
- Simultaneous read and write when empty: only the write is accepted. Count becomes 1 and `underflow_flag` is set.
- Status flags are decoded from the registered `word_count` and are glitch-free.
- Error flags are sticky until `rst_n` is asserted or `flush` is applied.
- `flush` takes priority over reads and writes in the same cycle. It zeroes both pointers and the count, clears both error flags and sets `read_valid` to 0. `read_data` and the array contents are not cleared.

## Timing
- Reset values:
  - `word_count` = 0
  - `empty_flag` = 1, `full_flag` = 0
  - `almost_empty` = 1, `almost_full` = 0
  - `read_data` = 0, `read_valid` = 0
  - `overflow_flag` = 0, `underflow_flag` = 0
  - both pointers = 0
- Asserting `rst_n` mid-operation discards all contents immediately, without waiting for a clock edge.
- Write-to-count latency: 1 cycle. A write accepted at edge N makes `word_count` and the flags reflect it after edge N.
- Read latency: 1 cycle. A read accepted at edge N presents `read_data` with `read_valid` = 1 after edge N.
- Fall-through: a write to an empty FIFO becomes readable at edge N+1 (no fall-through).
- Error flags set at the edge that samples the offending request.

## Configuration
- `SYNC_FIFO_SVA_EN` defined: concurrent assertions clocked on `clk`, disabled while !`rst_n`, are compiled in. They check:
  - `full_flag` ⇔ `word_count` == `DEPTH`
  - `empty_flag` ⇔ `word_count` == 0
  - `word_count` ≤ `DEPTH`
  - no count increment while full
  - no count decrement while empty
  - `full_flag` && `empty_flag` never both high
- Each assertion failure calls `$error` with a message.
- Not defined: no assertion code is compiled. Functional behaviour is identical either way.

## Test plan
- Reset, then 16 writes of 0x00..0x0F with `DEPTH`=16 → `word_count` = 16, `full_flag` = 1, `almost_full` = 1, `overflow_flag` = 0.
- Full FIFO, a 17th write of 0xAA → `word_count` stays 16, `overflow_flag` = 1. A subsequent 16 reads return 0x00..0x0F in order, and `read_valid` is high on each.
- Empty FIFO, `read_enable` = 1 for 1 cycle → `underflow_flag` = 1, `read_valid` = 0, `read_data` unchanged, `empty_flag` = 1.
- Count held at 8, then simultaneous read and write for 20 cycles → `word_count` stays 8, pointers wrap past 15 and data order is preserved.
- FIFO at 5 entries with both error flags set, then `flush` pulsed together with `write_enable` → `word_count` = 0, `empty_flag` = 1, both error flags = 0.
- `rst_n` driven low mid-burst between edges → all outputs take their reset values immediately. With `SYNC_FIFO_SVA_EN` defined, no assertion fires across the whole run.
